hazard_stall_controller: RTL and testbench

- Sequences the 5-stage pipeline: generates the PC enable, IF/ID enable and flush, the cu_mux bubble select, and a back-end freeze.
- Handles three cases: load-use hazards (multi-cycle configurable), taken-branch squash, and data-memory busy freezes.
- Sits beside the control unit. Consumes decoded ID-stage register fields plus ID/EX and EX-stage status, and drives the pipeline-register enables.

---
 rtl/hazard_stall_controller.sv | 141 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for a 5-stage core: load-use bubbles, taken-branch squash
// and data-memory freeze, with saturating stall/flush event counters.
module hazard_stall_controller #(
   parameter int LOAD_USE_LAT = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       id_rn,
   input  logic             id_rn_used,
   input  logic [3:0]       id_rm,
   input  logic             id_rm_used,
   input  logic [3:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_to_reg,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_enable,
   output logic             pc_src_select,
   output logic             if_id_enable,
   output logic             if_id_flush,
   output logic             bubble_select,
   output logic             pipe_freeze,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // state       | meaning
   // RUN         | normal flow; load-use hazards checked every cycle
   // LOAD_STALL  | extra load-use bubbles pending, lat_cnt = bubbles left
   // MEM_WAIT    | data memory busy; whole pipe frozen, prior state saved
   typedef enum logic [1:0] {
      S_RUN        = 2'b00,
      S_LOAD_STALL = 2'b01,
      S_MEM_WAIT   = 2'b10
   } state_t;

   localparam logic [3:0]       LAT_INIT = 4'(LOAD_USE_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t     state;
   state_t     saved_state;
   logic [3:0] lat_cnt;
   logic [3:0] saved_lat;

   state_t     eff_state;
   logic [3:0] eff_lat;
   logic       lu_hazard;
   logic       stall_now;

   // Leaving MEM_WAIT resumes exactly where the freeze interrupted.
   always_comb begin
      eff_state = state;
      eff_lat   = lat_cnt;
      if (state == S_MEM_WAIT) begin
         eff_state = saved_state;
         eff_lat   = saved_lat;
      end
   end

   always_comb begin
      lu_hazard = ex_mem_to_reg & ex_reg_write &
                  ((id_rn_used & (id_rn == ex_rd)) | (id_rm_used & (id_rm == ex_rd)));
      stall_now = (eff_state == S_LOAD_STALL) | lu_hazard;
   end

   always_comb begin
      pc_enable     = 1'b1;
      pc_src_select = 1'b0;
      if_id_enable  = 1'b1;
      if_id_flush   = 1'b0;
      bubble_select = 1'b0;
      pipe_freeze   = 1'b0;
      if (!reset) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         if_id_flush   = 1'b1;
         bubble_select = 1'b1;
      end else if (mem_busy) begin
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
         pipe_freeze  = 1'b1;
      end else if (ex_branch_taken) begin
         pc_src_select = 1'b1;
         if_id_flush   = 1'b1;
         bubble_select = 1'b1;
      end else if (stall_now) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         bubble_select = 1'b1;
      end
   end

   assign ctrl_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_RUN;
         lat_cnt     <= 4'd0;
         saved_state <= S_RUN;
         saved_lat   <= 4'd0;
         stall_count <= '0;
         flush_count <= '0;
      end else if (mem_busy) begin
         if (state != S_MEM_WAIT) begin
            saved_state <= state;
            saved_lat   <= lat_cnt;
         end
         state <= S_MEM_WAIT;
         if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
      end else if (ex_branch_taken) begin
         state   <= S_RUN;
         lat_cnt <= 4'd0;
         if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
      end else if (eff_state == S_LOAD_STALL) begin
         if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
         if (eff_lat == 4'd1) begin
            state   <= S_RUN;
            lat_cnt <= 4'd0;
         end else begin
            state   <= S_LOAD_STALL;
            lat_cnt <= eff_lat - 4'd1;
         end
      end else if (lu_hazard) begin
         if (stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
         if (LAT_INIT != 4'd0) begin
            state   <= S_LOAD_STALL;
            lat_cnt <= LAT_INIT;
         end else begin
            state   <= S_RUN;
            lat_cnt <= 4'd0;
         end
      end else begin
         state   <= S_RUN;
         lat_cnt <= 4'd0;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (LAT=1, LAT=3, LAT=1/CNT_W=4)
// share one stimulus stream and are checked every cycle against a bubble-count model.
module tb_hazard_stall_controller;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [3:0] id_rn = '0, id_rm = '0, ex_rd = '0;
   logic id_rn_used = 0, id_rm_used = 0, ex_reg_write = 0, ex_mem_to_reg = 0;
   logic ex_branch_taken = 0, mem_busy = 0;

   logic [2:0] pe, ps, ie, fl, bs, pf;
   logic [1:0] cs0, cs1, cs2;
   logic [15:0] sc0, sc1, fc0, fc1;
   logic [3:0]  sc2, fc2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_stall_controller #(.LOAD_USE_LAT(1), .CNT_W(16)) d1 (
      .clk(clk), .reset(reset), .id_rn(id_rn), .id_rn_used(id_rn_used), .id_rm(id_rm),
      .id_rm_used(id_rm_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_enable(pe[0]), .pc_src_select(ps[0]), .if_id_enable(ie[0]), .if_id_flush(fl[0]),
      .bubble_select(bs[0]), .pipe_freeze(pf[0]), .ctrl_state(cs0),
      .stall_count(sc0), .flush_count(fc0));

   hazard_stall_controller #(.LOAD_USE_LAT(3), .CNT_W(16)) d3 (
      .clk(clk), .reset(reset), .id_rn(id_rn), .id_rn_used(id_rn_used), .id_rm(id_rm),
      .id_rm_used(id_rm_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_enable(pe[1]), .pc_src_select(ps[1]), .if_id_enable(ie[1]), .if_id_flush(fl[1]),
      .bubble_select(bs[1]), .pipe_freeze(pf[1]), .ctrl_state(cs1),
      .stall_count(sc1), .flush_count(fc1));

   hazard_stall_controller #(.LOAD_USE_LAT(1), .CNT_W(4)) ds (
      .clk(clk), .reset(reset), .id_rn(id_rn), .id_rn_used(id_rn_used), .id_rm(id_rm),
      .id_rm_used(id_rm_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_enable(pe[2]), .pc_src_select(ps[2]), .if_id_enable(ie[2]), .if_id_flush(fl[2]),
      .bubble_select(bs[2]), .pipe_freeze(pf[2]), .ctrl_state(cs2),
      .stall_count(sc2), .flush_count(fc2));

   // Model: bubbles still owed, whether last cycle was frozen, and event totals.
   int lat_of [3] = '{1, 3, 1};
   int max_of [3] = '{65535, 65535, 15};
   int m_pend [3] = '{0, 0, 0};
   int m_stall[3] = '{0, 0, 0};
   int m_flush[3] = '{0, 0, 0};
   bit m_pbusy[3] = '{0, 0, 0};
   int n_pend [3] = '{0, 0, 0};
   int n_stall[3] = '{0, 0, 0};
   int n_flush[3] = '{0, 0, 0};
   bit n_pbusy[3] = '{0, 0, 0};

   function automatic logic [7:0] observed(int k);
      logic [1:0] cs;
      cs = (k == 0) ? cs0 : (k == 1) ? cs1 : cs2;
      return {pe[k], ps[k], ie[k], fl[k], bs[k], pf[k], cs};
   endfunction

   function automatic int obs_stall(int k);
      return (k == 0) ? int'(sc0) : (k == 1) ? int'(sc1) : int'(sc2);
   endfunction

   function automatic int obs_flush(int k);
      return (k == 0) ? int'(fc0) : (k == 1) ? int'(fc1) : int'(fc2);
   endfunction

   function automatic bit hazard_now();
      return ex_mem_to_reg && ex_reg_write &&
             ((id_rn_used && id_rn == ex_rd) || (id_rm_used && id_rm == ex_rd));
   endfunction

   task automatic check(string name, int k, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic [5:0] ctl;
         logic [1:0] st;
         bit hz;
         hz = hazard_now();
         if (!reset) begin
            ctl = 6'b000110; st = 2'd0;
         end else begin
            st = m_pbusy[k] ? 2'd2 : (m_pend[k] > 0 ? 2'd1 : 2'd0);
            if (mem_busy)                  ctl = 6'b000001;
            else if (ex_branch_taken)      ctl = 6'b111110;
            else if (m_pend[k] > 0 || hz)  ctl = 6'b000010;
            else                           ctl = 6'b101000;
         end
         check("outputs", k, int'(observed(k)), int'({ctl, st}));
         check("stall_count", k, obs_stall(k), m_stall[k]);
         check("flush_count", k, obs_flush(k), m_flush[k]);

         n_pend[k] = m_pend[k]; n_stall[k] = m_stall[k];
         n_flush[k] = m_flush[k]; n_pbusy[k] = 0;
         if (!reset) begin
            n_pend[k] = 0; n_stall[k] = 0; n_flush[k] = 0;
         end else if (mem_busy) begin
            n_pbusy[k] = 1;
            if (m_stall[k] < max_of[k]) n_stall[k] = m_stall[k] + 1;
         end else if (ex_branch_taken) begin
            n_pend[k] = 0;
            if (m_flush[k] < max_of[k]) n_flush[k] = m_flush[k] + 1;
         end else if (m_pend[k] > 0 || hz) begin
            n_pend[k] = (m_pend[k] > 0) ? m_pend[k] - 1 : lat_of[k] - 1;
            if (m_stall[k] < max_of[k]) n_stall[k] = m_stall[k] + 1;
         end
      end
   end

   always @(posedge clk or negedge reset) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            m_pend[k] <= 0; m_stall[k] <= 0; m_flush[k] <= 0; m_pbusy[k] <= 0;
         end else begin
            m_pend[k] <= n_pend[k]; m_stall[k] <= n_stall[k];
            m_flush[k] <= n_flush[k]; m_pbusy[k] <= n_pbusy[k];
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_hazard(logic [3:0] rd, logic [3:0] rn, logic rn_u,
                             logic [3:0] rm, logic rm_u, logic wr, logic ld);
      ex_rd = rd; id_rn = rn; id_rn_used = rn_u; id_rm = rm; id_rm_used = rm_u;
      ex_reg_write = wr; ex_mem_to_reg = ld;
   endtask

   task automatic clear_hazard();
      set_hazard(4'd0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      clear_hazard();
      cyc(2);
      check("lit_reset_pc_en", 0, int'(pe[0]), 0);
      check("lit_reset_flush", 0, int'(fl[0]), 1);
      check("lit_reset_bubble", 0, int'(bs[0]), 1);
      reset = 1'b1;
      cyc(5);
      check("lit_idle_pc_en", 0, int'(pe[0]), 1);
      check("lit_idle_stall", 0, int'(sc0), 0);

      // one-cycle load-use on rn
      set_hazard(4'd2, 4'd2, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
      #3;
      check("lit_lu_bubble", 0, int'(bs[0]), 1);
      check("lit_lu_pc_en", 0, int'(pe[0]), 0);
      cyc(1);
      clear_hazard();
      check("lit_lat3_state", 1, int'(cs1), 1);
      cyc(4);
      check("lit_lat1_stall", 0, int'(sc0), 1);
      check("lit_lat3_stall", 1, int'(sc1), 3);
      check("lit_lat1_state", 0, int'(cs0), 0);

      // rm match but unused, then used; R15; no reg_write
      set_hazard(4'd2, 4'd5, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
      cyc(2);
      check("lit_rm_unused", 0, int'(sc0), 1);
      set_hazard(4'd2, 4'd5, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1);
      cyc(1);
      clear_hazard();
      cyc(4);
      set_hazard(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
      cyc(1);
      clear_hazard();
      cyc(4);
      set_hazard(4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
      cyc(2);
      clear_hazard();
      cyc(2);
      check("lit_r15_lat3", 1, int'(sc1), 9);

      // branch in second cycle of a LAT=3 stall
      set_hazard(4'd4, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
      cyc(1);
      clear_hazard();
      ex_branch_taken = 1'b1;
      #3;
      check("lit_br_flush", 1, int'(fl[1]), 1);
      check("lit_br_pcsrc", 1, int'(ps[1]), 1);
      cyc(1);
      ex_branch_taken = 1'b0;
      check("lit_br_state", 1, int'(cs1), 0);
      check("lit_br_fcount", 1, int'(fc1), 1);
      check("lit_br_scount", 1, int'(sc1), 10);
      cyc(3);

      // memory busy during LOAD_STALL with two bubbles left
      set_hazard(4'd6, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1);
      cyc(1);
      clear_hazard();
      mem_busy = 1'b1;
      cyc(4);
      mem_busy = 1'b0;
      check("lit_mw_state", 1, int'(cs1), 2);
      check("lit_mw_stall", 1, int'(sc1), 15);
      cyc(1);
      check("lit_mw_resume", 1, int'(cs1), 1);
      cyc(3);
      check("lit_mw_total", 1, int'(sc1), 17);

      // branch held across a freeze
      ex_branch_taken = 1'b1; mem_busy = 1'b1;
      cyc(2);
      mem_busy = 1'b0;
      cyc(1);
      ex_branch_taken = 1'b0;
      cyc(2);
      check("lit_br_after_mw", 0, int'(fc0), 2);

      // async reset in the middle of a freeze
      mem_busy = 1'b1;
      cyc(2);
      #2;
      reset = 1'b0;
      #1;
      check("lit_async_pc_en", 0, int'(pe[0]), 0);
      check("lit_async_freeze", 0, int'(pf[0]), 0);
      check("lit_async_flush", 0, int'(fl[0]), 1);
      check("lit_async_stall", 0, int'(sc0), 0);
      mem_busy = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(3);
      check("lit_post_rst_state", 1, int'(cs1), 0);
      check("lit_post_rst_stall", 1, int'(sc1), 0);

      // saturation of the 4-bit counter
      set_hazard(4'd9, 4'd9, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
      cyc(20);
      clear_hazard();
      cyc(4);
      check("lit_sat_w4", 2, int'(sc2), 15);
      check("lit_sat_w16", 0, int'(sc0), 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
